// File: rtl/ads127l01_acq_ctrl.sv
// ads127l01_acq_ctrl
//   Start-up sequencer and frame-mode serial capture for an ADS127L01 ADC.
//   The sequencer pulses the ADC reset, waits for it to settle, then asserts
//   START. While running, 24-bit samples framed by FSYNC are shifted in MSB
//   first, sign-extended, and queued in a first-word-fall-through FIFO.
//
// Ports
//   aclk, areset        : system clock (rising edge), async active-high reset
//   enable              : acquisition enable; dropping it returns to IDLE
//   sck, dout, fsync    : ADC serial interface, asynchronous to aclk
//   adc_reset_n         : ADC reset pin (low in IDLE/RESET)
//   adc_start           : ADC START pin (high only in RUN)
//   rd_en               : pop the FIFO head (ignored when empty)
//   rd_data             : FIFO head, sign-extended to 32 bits, 0 when empty
//   rd_cnt              : number of words held in the FIFO
//   overflow, frame_err : sticky error flags, cleared by clr_flags
//   state               : IDLE=0, RESET=1, SETTLE=2, RUN=3
module ads127l01_acq_ctrl #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RST_CYC    = 64,
  parameter int unsigned SETTLE_CYC = 256
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   enable,
  input  logic                   sck,
  input  logic                   dout,
  input  logic                   fsync,
  output logic                   adc_reset_n,
  output logic                   adc_start,
  input  logic                   rd_en,
  output logic [31:0]            rd_data,
  output logic [$clog2(DEPTH):0] rd_cnt,
  output logic                   overflow,
  output logic                   frame_err,
  input  logic                   clr_flags,
  output logic [1:0]             state
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned SEQ_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int unsigned CW      = $clog2(SEQ_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESET  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers. Bit [1] of each chain is the synchronized level;
  // bit [2] of sck/fsync is its one-cycle-delayed copy for edge detection.
  // dout has the same two-flop latency as sck, so it is stable when the
  // synchronized sck rise is seen.
  // ---------------------------------------------------------------------------
  logic [2:0] sck_q;
  logic [2:0] fsync_q;
  logic [1:0] dout_q;
  logic       sck_rise;
  logic       fsync_rise;
  logic       dout_s;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sck_q   <= '0;
      fsync_q <= '0;
      dout_q  <= '0;
    end else begin
      sck_q   <= {sck_q[1:0], sck};
      fsync_q <= {fsync_q[1:0], fsync};
      dout_q  <= {dout_q[0], dout};
    end
  end

  assign sck_rise   = sck_q[1] & ~sck_q[2];
  assign fsync_rise = fsync_q[1] & ~fsync_q[2];
  assign dout_s     = dout_q[1];

  // ---------------------------------------------------------------------------
  // Start-up sequencer. Pin outputs are registered together with the state so
  // they change on exactly the same edge as the state they belong to.
  // ---------------------------------------------------------------------------
  state_t          st_q;
  logic [CW-1:0]   seq_cnt_q;
  logic            adc_reset_n_q;
  logic            adc_start_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      st_q          <= ST_IDLE;
      seq_cnt_q     <= '0;
      adc_reset_n_q <= 1'b0;
      adc_start_q   <= 1'b0;
    end else if (!enable) begin
      st_q          <= ST_IDLE;
      seq_cnt_q     <= '0;
      adc_reset_n_q <= 1'b0;
      adc_start_q   <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          st_q      <= ST_RESET;
          seq_cnt_q <= '0;
        end
        ST_RESET: begin
          if (seq_cnt_q == CW'(RST_CYC - 1)) begin
            st_q          <= ST_SETTLE;
            seq_cnt_q     <= '0;
            adc_reset_n_q <= 1'b1;
          end else begin
            seq_cnt_q <= seq_cnt_q + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (seq_cnt_q == CW'(SETTLE_CYC - 1)) begin
            st_q        <= ST_RUN;
            seq_cnt_q   <= '0;
            adc_start_q <= 1'b1;
          end else begin
            seq_cnt_q <= seq_cnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          st_q <= ST_RUN;
        end
        default: begin
          st_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign state       = st_q;
  assign adc_reset_n = adc_reset_n_q;
  assign adc_start   = adc_start_q;

  // ---------------------------------------------------------------------------
  // Frame capture. A frame closes itself after the 24th bit, so later sck
  // pulses are ignored until the next fsync. Capture is also abandoned in the
  // cycle enable drops, since the sequencer leaves RUN on the next edge.
  // ---------------------------------------------------------------------------
  logic        in_frame_q, in_frame_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic        push_q, push_d;
  logic        ferr_evt;

  always_comb begin
    in_frame_d = in_frame_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push_d     = 1'b0;
    ferr_evt   = 1'b0;
    if (st_q != ST_RUN || !enable) begin
      in_frame_d = 1'b0;
      bit_cnt_d  = '0;
    end else if (fsync_rise) begin
      // An open frame here means fewer than 24 bits arrived.
      ferr_evt   = in_frame_q;
      in_frame_d = 1'b1;
      bit_cnt_d  = '0;
      shift_d    = '0;
    end else if (sck_rise && in_frame_q) begin
      shift_d   = {shift_q[22:0], dout_s};
      bit_cnt_d = bit_cnt_q + 5'd1;
      if (bit_cnt_q == 5'd23) begin
        in_frame_d = 1'b0;
        push_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      in_frame_q <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
    end else begin
      in_frame_q <= in_frame_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      push_q     <= push_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT sample FIFO. A pop frees a slot in the same cycle, so a push into a
  // full FIFO with a simultaneous pop is accepted and does not overflow.
  // ---------------------------------------------------------------------------
  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full;
  logic          do_push;
  logic          do_pop;
  logic          ovf_evt;
  logic          overflow_q, overflow_d;
  logic          frame_err_q, frame_err_d;
  logic [23:0]   head;

  assign full    = (cnt_q == (AW + 1)'(DEPTH));
  assign do_pop  = rd_en && (cnt_q != '0);
  assign do_push = push_q && (!full || do_pop);
  assign ovf_evt = push_q && full && !do_pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (AW + 1)'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - (AW + 1)'(1);
    end
    // Set events take priority over a same-cycle clear.
    if (clr_flags) begin
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end
    if (ovf_evt) begin
      overflow_d = 1'b1;
    end
    if (ferr_evt) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage needs no reset: rd_cnt gates every read.
  always_ff @(posedge aclk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign rd_data   = (cnt_q != '0) ? {{8{head[23]}}, head} : '0;
  assign rd_cnt    = cnt_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ads127l01_acq_ctrl.sv
// tb_ads127l01_acq_ctrl
//   Self-checking bench. A queue-based model of the FIFO and flags predicts
//   rd_cnt, rd_data, overflow and frame_err from the frames the bench sends.
module tb_ads127l01_acq_ctrl;

  localparam int unsigned DEPTH = 16;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        enable = 1'b0;
  logic        sck = 1'b0;
  logic        dout = 1'b0;
  logic        fsync = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_flags = 1'b0;
  logic        adc_reset_n;
  logic        adc_start;
  logic [31:0] rd_data;
  logic [4:0]  rd_cnt;
  logic        overflow;
  logic        frame_err;
  logic [1:0]  state;

  int unsigned total = 0;
  int unsigned bad = 0;

  // Reference model
  logic [23:0] model_q[$];
  logic        m_ovf = 1'b0;
  logic        m_ferr = 1'b0;
  bit          m_partial = 1'b0;

  always #5 aclk = ~aclk;

  ads127l01_acq_ctrl #(
    .DEPTH(DEPTH),
    .RST_CYC(64),
    .SETTLE_CYC(256)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .enable(enable),
    .sck(sck),
    .dout(dout),
    .fsync(fsync),
    .adc_reset_n(adc_reset_n),
    .adc_start(adc_start),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_cnt(rd_cnt),
    .overflow(overflow),
    .frame_err(frame_err),
    .clr_flags(clr_flags),
    .state(state)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] sext24(input logic [23:0] v);
    int signed s;
    s = (v >= 24'h800000) ? (int'(v) - 16777216) : int'(v);
    return 32'(s);
  endfunction

  function automatic logic [31:0] exp_head();
    if (model_q.size() == 0) return 32'h0;
    return sext24(model_q[0]);
  endfunction

  // Sends fsync followed by nbits of data MSB first. With pop_on_push, rd_en
  // is raised for the single cycle in which the completed word is written.
  task automatic send_frame(input logic [23:0] data, input int unsigned nbits,
                            input bit pop_on_push);
    if (m_partial) m_ferr = 1'b1;
    m_partial = 1'b1;
    @(negedge aclk);
    fsync = 1'b1;
    repeat (4) @(negedge aclk);
    fsync = 1'b0;
    for (int unsigned i = 0; i < nbits; i++) begin
      dout = data[23 - i];
      sck = 1'b0;
      repeat (4) @(negedge aclk);
      sck = 1'b1;
      if (pop_on_push && i == 23) begin
        repeat (3) @(negedge aclk);
        rd_en = 1'b1;
        @(negedge aclk);
        rd_en = 1'b0;
      end else begin
        repeat (4) @(negedge aclk);
      end
    end
    if (nbits == 24) begin
      m_partial = 1'b0;
      if (pop_on_push) begin
        void'(model_q.pop_front());
        model_q.push_back(data);
      end else if (model_q.size() < DEPTH) begin
        model_q.push_back(data);
      end else begin
        m_ovf = 1'b1;
      end
    end
    repeat (8) @(negedge aclk);
  endtask

  task automatic pop_one();
    @(negedge aclk);
    rd_en = 1'b1;
    @(negedge aclk);
    rd_en = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic clear_flags();
    @(negedge aclk);
    clr_flags = 1'b1;
    @(negedge aclk);
    clr_flags = 1'b0;
    m_ovf = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int unsigned guard;
    guard = 0;
    while (state !== 2'd3 && guard < 1000) begin
      @(negedge aclk);
      guard++;
    end
    total++;
    if (state !== 2'd3) begin
      bad++;
      $display("FAIL %s_reach_run: got state %0d want 3", tag, state);
    end
  endtask

  task automatic test_reset();
    @(negedge aclk);
    sck = 1'b1; fsync = 1'b1; dout = 1'b1; rd_en = 1'b1;
    repeat (3) @(negedge aclk);
    total++;
    if (state !== 2'd0 || adc_reset_n !== 1'b0 || adc_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got state=%0d rstn=%b start=%b want 0/0/0", state, adc_reset_n, adc_start);
    end
    total++;
    if (rd_cnt !== 5'd0 || rd_data !== 32'h0 || overflow !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_fifo: got cnt=%0d data=%h ovf=%b ferr=%b want 0", rd_cnt, rd_data, overflow, frame_err);
    end
    sck = 1'b0; fsync = 1'b0; dout = 1'b0; rd_en = 1'b0;
    areset = 1'b0;
    repeat (5) @(negedge aclk);
    total++;
    if (state !== 2'd0) begin
      bad++;
      $display("FAIL reset_idle_wait: got state %0d want 0", state);
    end
  endtask

  task automatic test_startup();
    int unsigned n_rst, n_set, guard;
    bit pin_bad;
    @(negedge aclk);
    enable = 1'b1;
    @(negedge aclk);
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL startup_enter_reset: got state %0d want 1", state);
    end
    n_rst = 0; guard = 0; pin_bad = 1'b0;
    while (state === 2'd1 && guard < 1000) begin
      if (adc_reset_n !== 1'b0 || adc_start !== 1'b0) pin_bad = 1'b1;
      n_rst++; guard++;
      @(negedge aclk);
    end
    total++;
    if (n_rst != 64 || pin_bad) begin
      bad++;
      $display("FAIL startup_reset_len: got %0d cycles pins_bad=%0d want 64 cycles pins_bad=0", n_rst, pin_bad);
    end
    total++;
    if (state !== 2'd2) begin
      bad++;
      $display("FAIL startup_enter_settle: got state %0d want 2", state);
    end
    n_set = 0; guard = 0; pin_bad = 1'b0;
    while (state === 2'd2 && guard < 1000) begin
      if (adc_reset_n !== 1'b1 || adc_start !== 1'b0) pin_bad = 1'b1;
      n_set++; guard++;
      @(negedge aclk);
    end
    total++;
    if (n_set != 256 || pin_bad) begin
      bad++;
      $display("FAIL startup_settle_len: got %0d cycles pins_bad=%0d want 256 cycles pins_bad=0", n_set, pin_bad);
    end
    total++;
    if (state !== 2'd3 || adc_reset_n !== 1'b1 || adc_start !== 1'b1) begin
      bad++;
      $display("FAIL startup_run: got state=%0d rstn=%b start=%b want 3/1/1", state, adc_reset_n, adc_start);
    end
  endtask

  task automatic test_capture();
    send_frame(24'h800001, 24, 1'b0);
    total++;
    if (rd_cnt !== 5'd1 || rd_data !== 32'hFF800001) begin
      bad++;
      $display("FAIL capture_neg: got cnt=%0d data=%h want 1 ff800001", rd_cnt, rd_data);
    end
    send_frame(24'h7FFFFF, 24, 1'b0);
    pop_one();
    total++;
    if (rd_cnt !== 5'd1 || rd_data !== 32'h007FFFFF) begin
      bad++;
      $display("FAIL capture_pos: got cnt=%0d data=%h want 1 007fffff", rd_cnt, rd_data);
    end
    pop_one();
    pop_one();
    total++;
    if (rd_cnt !== 5'd0 || rd_data !== 32'h0) begin
      bad++;
      $display("FAIL capture_empty_pop: got cnt=%0d data=%h want 0 0", rd_cnt, rd_data);
    end
  endtask

  task automatic test_random_traffic();
    for (int unsigned it = 0; it < 12; it++) begin
      send_frame(24'($urandom()), 24, 1'b0);
      for (int unsigned p = $urandom_range(0, 2); p > 0; p--) pop_one();
      total++;
      if (rd_cnt !== 5'(model_q.size()) || rd_data !== exp_head()) begin
        bad++;
        $display("FAIL random_step%0d: got cnt=%0d data=%h want %0d %h", it, rd_cnt, rd_data, model_q.size(), exp_head());
      end
    end
    while (model_q.size() > 0) pop_one();
    total++;
    if (rd_cnt !== 5'd0 || overflow !== m_ovf || frame_err !== m_ferr) begin
      bad++;
      $display("FAIL random_drain: got cnt=%0d ovf=%b ferr=%b want 0 %b %b", rd_cnt, overflow, frame_err, m_ovf, m_ferr);
    end
  endtask

  task automatic test_overflow();
    logic [23:0] sent[17];
    clear_flags();
    for (int unsigned i = 0; i < 17; i++) begin
      sent[i] = 24'($urandom());
      send_frame(sent[i], 24, 1'b0);
    end
    total++;
    if (rd_cnt !== 5'd16 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_full: got cnt=%0d ovf=%b want 16 1", rd_cnt, overflow);
    end
    for (int unsigned i = 0; i < 16; i++) begin
      total++;
      if (rd_data !== sext24(sent[i])) begin
        bad++;
        $display("FAIL overflow_order%0d: got %h want %h", i, rd_data, sext24(sent[i]));
      end
      pop_one();
    end
    total++;
    if (rd_cnt !== 5'd0 || rd_data !== 32'h0) begin
      bad++;
      $display("FAIL overflow_drained: got cnt=%0d data=%h want 0 0", rd_cnt, rd_data);
    end
    clear_flags();
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear: got %b want 0", overflow);
    end
  endtask

  task automatic test_short_frame();
    send_frame(24'($urandom()), 10, 1'b0);
    send_frame(24'h123456, 24, 1'b0);
    total++;
    if (frame_err !== 1'b1 || rd_cnt !== 5'd1 || rd_data !== 32'h00123456) begin
      bad++;
      $display("FAIL short_frame: got ferr=%b cnt=%0d data=%h want 1 1 00123456", frame_err, rd_cnt, rd_data);
    end
    pop_one();
    clear_flags();
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL short_frame_clear: got %b want 0", frame_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] v;
    for (int unsigned i = 0; i < 16; i++) send_frame(24'($urandom()), 24, 1'b0);
    total++;
    if (rd_cnt !== 5'd16 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL b2b_fill: got cnt=%0d ovf=%b want 16 0", rd_cnt, overflow);
    end
    v = 24'($urandom());
    send_frame(v, 24, 1'b1);
    total++;
    if (rd_cnt !== 5'd16 || overflow !== 1'b0 || rd_data !== exp_head()) begin
      bad++;
      $display("FAIL b2b_push_pop: got cnt=%0d ovf=%b data=%h want 16 0 %h", rd_cnt, overflow, rd_data, exp_head());
    end
    for (int unsigned i = 0; i < 16; i++) begin
      total++;
      if (rd_data !== exp_head()) begin
        bad++;
        $display("FAIL b2b_drain%0d: got %h want %h", i, rd_data, exp_head());
      end
      pop_one();
    end
  endtask

  task automatic test_enable_mid_frame();
    logic [23:0] a, b;
    a = 24'($urandom());
    b = 24'($urandom());
    send_frame(a, 24, 1'b0);
    send_frame(24'($urandom()), 12, 1'b0);
    @(negedge aclk);
    enable = 1'b0;
    m_partial = 1'b0;
    repeat (2) @(negedge aclk);
    total++;
    if (state !== 2'd0 || adc_reset_n !== 1'b0 || adc_start !== 1'b0 || rd_cnt !== 5'd1) begin
      bad++;
      $display("FAIL enable_drop: got state=%0d rstn=%b start=%b cnt=%0d want 0 0 0 1", state, adc_reset_n, adc_start, rd_cnt);
    end
    enable = 1'b1;
    wait_run("enable");
    send_frame(b, 24, 1'b0);
    total++;
    if (rd_cnt !== 5'd2 || frame_err !== m_ferr || rd_data !== sext24(a)) begin
      bad++;
      $display("FAIL enable_resume: got cnt=%0d ferr=%b data=%h want 2 %b %h", rd_cnt, frame_err, rd_data, m_ferr, sext24(a));
    end
    pop_one();
    total++;
    if (rd_data !== sext24(b)) begin
      bad++;
      $display("FAIL enable_resume_word: got %h want %h", rd_data, sext24(b));
    end
    pop_one();
  endtask

  task automatic test_areset_mid_frame();
    logic [23:0] v;
    send_frame(24'($urandom()), 5, 1'b0);
    send_frame(24'($urandom()), 24, 1'b0);
    send_frame(24'($urandom()), 12, 1'b0);
    @(negedge aclk);
    areset = 1'b1;
    #1;
    total++;
    if (state !== 2'd0 || adc_reset_n !== 1'b0 || adc_start !== 1'b0 || rd_cnt !== 5'd0 ||
        rd_data !== 32'h0 || overflow !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL areset_mid: got state=%0d rstn=%b start=%b cnt=%0d data=%h ovf=%b ferr=%b want all 0",
               state, adc_reset_n, adc_start, rd_cnt, rd_data, overflow, frame_err);
    end
    model_q.delete();
    m_ovf = 1'b0; m_ferr = 1'b0; m_partial = 1'b0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL areset_restart: got state %0d want 1", state);
    end
    wait_run("areset");
    v = 24'($urandom());
    send_frame(v, 24, 1'b0);
    total++;
    if (rd_cnt !== 5'd1 || rd_data !== sext24(v) || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL areset_after: got cnt=%0d data=%h ferr=%b want 1 %h 0", rd_cnt, rd_data, frame_err, sext24(v));
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_capture();
    test_random_traffic();
    test_overflow();
    test_short_frame();
    test_back_to_back();
    test_enable_mid_frame();
    test_areset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
